ad_sample_sched: RTL and testbench
==================================

Name: ad_sample_sched

Overview:
Sample-rate scheduler sitting in front of the AD7606 acquisition controller. It issues single-cycle conversion-start pulses at a programmable period and tracks completion through the controller's busy/valid handshake. It supports finite bursts or continuous capture, and flags overruns and lost conversions. It is the only source of conversion requests to the AD7606 control path.

Parameters:
DIV_W, 24, width of period divider (period in clk cycles)
CNT_W, 16, width of burst length and sample counter
OVR_W, 8, width of saturating overrun counter
TIMEOUT_CYC, 1000, max clk cycles allowed from conv_start to ad_valid

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
cfg_div  in  DIV_W  period minus one; latched on accepted cmd_start; values 0 and 1 both mean period 2
cfg_burst  in  CNT_W  samples per burst; 0 = continuous; latched on accepted cmd_start
cmd_start  in  1  start pulse; ignored while running=1
cmd_stop  in  1  abort request; has priority over cmd_start
ad_busy  in  1  acquisition controller busy
ad_valid  in  1  one-cycle pulse, channel result delivered
conv_start  out  1  registered one-cycle conversion request
running  out  1  high outside IDLE
done  out  1  one-cycle pulse when a burst completes normally
sample_cnt  out  CNT_W  completed samples in current run
overrun_cnt  out  OVR_W  ticks skipped because the previous sample was incomplete; saturates
timeout_err  out  1  sticky; a conversion exceeded TIMEOUT_CYC

Behaviour:
- Reset: all outputs 0; state IDLE; timer 0; latched config 0.
- States: IDLE, TRIG, WAIT_DONE, WAIT_TICK, DRAIN.
- IDLE:
  - cmd_start=1 and cmd_stop=0 → latch config, clear sample_cnt/overrun_cnt/timeout_err, clear timer, go to TRIG.
  - The first trigger is immediate, not tick-aligned.
- Timer:
  - Runs while running=1. Counts 0..D, where D = max(cfg_div,1).
  - Asserts tick for one cycle at D, then wraps to 0.
  - Period is D+1 cycles, measured from the start edge.
- TRIG:
  - ad_busy=0 → next edge: conv_start=1 for exactly one cycle, go to WAIT_DONE.
  - ad_busy=1 → hold in TRIG.
- WAIT_DONE, on ad_valid:
  - Increment sample_cnt.
  - If cfg_burst≠0 and the new count equals cfg_burst → done pulse next cycle, go to IDLE.
  - Otherwise go to WAIT_TICK.
- WAIT_TICK: tick → TRIG.
- Overrun: a tick arriving while in TRIG or WAIT_DONE increments overrun_cnt (saturating at 2^OVR_W−1). No extra trigger is queued.
- Timeout:
  - A watchdog counts WAIT_DONE cycles.
  - On reaching TIMEOUT_CYC: set timeout_err, do not increment sample_cnt, go to WAIT_TICK.
  - In DRAIN, timeout goes to IDLE instead.
- ad_valid and tick in the same cycle in WAIT_DONE: the sample is counted and no overrun is recorded. The FSM goes to WAIT_TICK (the tick is consumed) and triggers on the next tick.
- cmd_stop:
  - From TRIG or WAIT_TICK → IDLE next edge.
  - From WAIT_DONE → DRAIN. DRAIN waits for ad_valid (counted) or timeout, then → IDLE.
  - No done pulse on a stop.
- Counters are left readable in IDLE until the next accepted start.
- Latency: cmd_start sampled at edge k, ad_busy=0 → conv_start high during cycle after edge k+1.
- rst mid-run: immediate return to reset values. An in-flight conversion is ignored.

Optional Feature:
AD_SCHED_EXT_TRIG_EN:
- Defined:
  - Adds input ext_trig (1 bit, synchronous to clk).
  - A rising edge, detected with a 1-cycle registered delay, replaces the internal tick.
  - The cfg_div timer is not instantiated.
  - The first trigger after start is still immediate.
- Undefined: port absent; internal timer only.

Decomposition:
- Shared package/header ad_sched_pkg holds:
  - state encodings IDLE/TRIG/WAIT_DONE/WAIT_TICK/DRAIN
  - minimum divider constant (1)
  - default TIMEOUT_CYC
- One sub-module, ad_sched_tick: divider counter with clear and enable inputs and a tick output.
- The ext-trigger edge detect lives in the top when the macro is set.

Test Plan:
- cfg_div=9, cfg_burst=4, ad_valid 3 cycles after each conv_start → 4 conv_start pulses 10 cycles apart (first 2 cycles after cmd_start); sample_cnt=4, done pulse once; overrun_cnt=0.
- cfg_div=4, ad_valid 12 cycles after conv_start, cfg_burst=3 → overrun_cnt=2 after the first sample; conv_start pulses only at ticks after completion.
- ad_busy held high 7 cycles after start → conv_start delayed until the cycle after ad_busy falls; no overrun if within period.
- ad_valid never returned, TIMEOUT_CYC=1000 → timeout_err=1 at cycle 1000 of WAIT_DONE; sample_cnt stays 0; next trigger on the following tick.
- cfg_burst=0, cmd_stop during WAIT_DONE → state DRAIN; ad_valid 2 cycles later → sample_cnt+1, running=0, no done.
- cmd_start and cmd_stop in the same cycle from IDLE → remains IDLE. rst asserted in WAIT_DONE → all outputs 0 next cycle.

Source files
------------

// File: rtl/ad_sched_pkg.sv
// ad_sched_pkg: shared state encoding and constants for the AD7606 sample scheduler.
package ad_sched_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_DONE = 3'd2,
      WAIT_TICK = 3'd3,
      DRAIN     = 3'd4
   } sched_state_e;

   // Smallest usable divider: 0 and 1 both give a 2-cycle period.
   localparam int MIN_DIV         = 1;
   localparam int TIMEOUT_CYC_DEF = 1000;

endpackage

// File: rtl/ad_sample_sched_if.sv
// ad_sample_sched_if: command/config, AD7606 controller handshake and status of the scheduler.
// Optional macro AD_SCHED_EXT_TRIG_EN adds the ext_trig input.
//
// Handshake: conv_start is a one-cycle request that is only issued while ad_busy=0;
// the controller later returns exactly one single-cycle ad_valid per accepted request.
// There is no back-pressure on ad_valid; cmd_start/cmd_stop are single-cycle pulses.
interface ad_sample_sched_if #(
   parameter int DIV_W = 24,
   parameter int CNT_W = 16,
   parameter int OVR_W = 8
);
   logic [DIV_W-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_burst;
   logic             cmd_start;
   logic             cmd_stop;
   logic             ad_busy;
   logic             ad_valid;
`ifdef AD_SCHED_EXT_TRIG_EN
   logic             ext_trig;
`endif
   logic             conv_start;
   logic             running;
   logic             done;
   logic [CNT_W-1:0] sample_cnt;
   logic [OVR_W-1:0] overrun_cnt;
   logic             timeout_err;

   modport master (
`ifdef AD_SCHED_EXT_TRIG_EN
      output ext_trig,
`endif
      output cfg_div, cfg_burst, cmd_start, cmd_stop, ad_busy, ad_valid,
      input  conv_start, running, done, sample_cnt, overrun_cnt, timeout_err
   );

   modport slave (
`ifdef AD_SCHED_EXT_TRIG_EN
      input  ext_trig,
`endif
      input  cfg_div, cfg_burst, cmd_start, cmd_stop, ad_busy, ad_valid,
      output conv_start, running, done, sample_cnt, overrun_cnt, timeout_err
   );
endinterface

// File: rtl/ad_sched_tick.sv
// ad_sched_tick: period divider counting 0..max(div_i,1), one-cycle tick at the top value.
module ad_sched_tick
   import ad_sched_pkg::*;
#(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] lim;

   // Clamp the terminal count so the period is never shorter than 2 cycles.
   always_comb begin
      lim    = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
      tick_o = en_i && (cnt_q == lim);
      cnt_d  = cnt_q;
      if (clr_i)       cnt_d = '0;
      else if (tick_o) cnt_d = '0;
      else if (en_i)   cnt_d = cnt_q + DIV_W'(1);
   end

   // Divider count register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ad_sample_sched.sv
// ad_sample_sched: periodic conversion-start scheduler for the AD7606 control path.
// Optional macro AD_SCHED_EXT_TRIG_EN replaces the internal divider tick with ext_trig rising edges.
module ad_sample_sched
   import ad_sched_pkg::*;
#(
   parameter int DIV_W       = 24,
   parameter int CNT_W       = 16,
   parameter int OVR_W       = 8,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   ad_sample_sched_if.slave bus,
   output sched_state_e     state_dbg_o
);
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   sched_state_e     state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] burst_q, burst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [OVR_W-1:0] ovr_q, ovr_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             terr_q, terr_d;
   logic             conv_q, conv_d;
   logic             done_q, done_d;
   logic             running, tick, tmo, ovr_sat;

   assign running = (state_q != IDLE);

`ifdef AD_SCHED_EXT_TRIG_EN
   logic trig_d1_q, trig_d2_q;

   // Delay ext_trig twice; a rising edge yields one tick one cycle after it is sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_d1_q <= 1'b0;
         trig_d2_q <= 1'b0;
      end else begin
         trig_d1_q <= bus.ext_trig;
         trig_d2_q <= trig_d1_q;
      end
   end

   assign tick = running & trig_d1_q & ~trig_d2_q;
`else
   // Divider is held at zero while idle so the period is measured from the start edge.
   ad_sched_tick #(.DIV_W(DIV_W)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (~running),
      .en_i   (running),
      .div_i  (div_q),
      .tick_o (tick)
   );
`endif

   // Next-state, counter and pulse logic of the scheduler FSM.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      terr_d  = terr_q;
      wd_d    = '0;
      conv_d  = 1'b0;
      done_d  = 1'b0;
      cnt_inc = cnt_q + CNT_W'(1);
      tmo     = (wd_q == WD_W'(TIMEOUT_CYC - 1));
      ovr_sat = &ovr_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_start && !bus.cmd_stop) begin
               div_d   = bus.cfg_div;
               burst_d = bus.cfg_burst;
               cnt_d   = '0;
               ovr_d   = '0;
               terr_d  = 1'b0;
               state_d = TRIG;
            end
         end
         TRIG: begin
            if (bus.cmd_stop) begin
               state_d = IDLE;
            end else begin
               if (tick && !ovr_sat) ovr_d = ovr_q + OVR_W'(1);
               if (!bus.ad_busy) begin
                  conv_d  = 1'b1;
                  state_d = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            wd_d = wd_q + WD_W'(1);
            if (bus.ad_valid) begin
               // A tick coinciding with completion is consumed, not an overrun.
               cnt_d = cnt_inc;
               wd_d  = '0;
               if (bus.cmd_stop) begin
                  state_d = IDLE;
               end else if ((burst_q != '0) && (cnt_inc == burst_q)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_TICK;
               end
            end else begin
               if (tick && !ovr_sat) ovr_d = ovr_q + OVR_W'(1);
               if (tmo) begin
                  terr_d  = 1'b1;
                  wd_d    = '0;
                  state_d = bus.cmd_stop ? IDLE : WAIT_TICK;
               end else if (bus.cmd_stop) begin
                  state_d = DRAIN;
               end
            end
         end
         WAIT_TICK: begin
            if (bus.cmd_stop)  state_d = IDLE;
            else if (tick)     state_d = TRIG;
         end
         DRAIN: begin
            // The watchdog keeps running across the stop: same conversion.
            wd_d = wd_q + WD_W'(1);
            if (bus.ad_valid) begin
               cnt_d   = cnt_inc;
               wd_d    = '0;
               state_d = IDLE;
            end else if (tmo) begin
               terr_d  = 1'b1;
               wd_d    = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latched configuration, counters and registered pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         ovr_q   <= '0;
         wd_q    <= '0;
         terr_q  <= 1'b0;
         conv_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
         wd_q    <= wd_d;
         terr_q  <= terr_d;
         conv_q  <= conv_d;
         done_q  <= done_d;
      end
   end

   assign bus.conv_start  = conv_q;
   assign bus.running     = running;
   assign bus.done        = done_q;
   assign bus.sample_cnt  = cnt_q;
   assign bus.overrun_cnt = ovr_q;
   assign bus.timeout_err = terr_q;
   assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_ad_sample_sched.sv
// tb_ad_sample_sched: bench for ad_sample_sched with a cycle-arithmetic reference model.
module tb_ad_sample_sched;
   import ad_sched_pkg::*;

   localparam int TMO = 1000;

   logic         clk = 1'b0;
   logic         rst;
   sched_state_e state_dbg;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_q[$];
   int          lat_q[$];

   ad_sample_sched_if bus ();

   ad_sample_sched #(.TIMEOUT_CYC(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .state_dbg_o (state_dbg)
   );

   // 50 MHz clock
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Number of tick cycles in [lo, hi]; cycle m (counted from the start edge) ticks when m mod p == p-1.
   function automatic int ticks(input int lo, input int hi, input int p);
      int n = 0;
      for (int m = lo; m <= hi; m++) if (m % p == p - 1) n++;
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after an edge; on return we are in cycle 0 (first cycle after the start edge).
   task automatic do_start(input int div, input int burst);
      bus.cfg_div   = div[23:0];
      bus.cfg_burst = burst[15:0];
      bus.cmd_start = 1'b1;
      bus.cmd_stop  = 1'b0;
      step();
      bus.cmd_start = 1'b0;
      bus.cfg_div   = 24'($urandom_range(0, 50));
      bus.cfg_burst = 16'($urandom_range(0, 9));
   endtask

   // One run: lat_q[i] is the ad_valid latency of conversion i (0 = never answered).
   task automatic run_case(input string name, input int div, input int burst, input int busy);
      int d = 0, p = 0, c = 0, lo = 0, v = 0, t = 0, cnt = 0, ovr = 0;
      int done_at = 0, terr_at = -1, terr_cnt = 0, idx = 0;
      int m = 0, conv_idx = 0, valid_at = -1, done_seen = 0;
      logic terr_seen = 1'b0;
      logic [31:0] e;

      d = (div < MIN_DIV) ? MIN_DIV : div;
      p = d + 1;
      exp_q.delete();
      c = busy + 1;
      while (cnt < burst && idx < lat_q.size()) begin
         exp_q.push_back(32'(c));
         if (lat_q[idx] != 0) begin
            v   = c + lat_q[idx];
            ovr += ticks(lo, v - 1, p);
            cnt++;
         end else begin
            v   = c + TMO - 1;
            ovr += ticks(lo, v, p);
            if (terr_at < 0) begin
               terr_at  = v + 1;
               terr_cnt = cnt;
            end
         end
         idx++;
         if (cnt == burst) begin
            done_at = v + 1;
         end else begin
            t = v + 1;
            while (t % p != d) t++;
            c  = t + 2;
            lo = t + 1;
         end
      end
      if (ovr > 255) ovr = 255;

      do_start(div, burst);
      check($sformatf("%s running_at_start", name), 32'(bus.running), 32'd1);
      while (m <= done_at + 2) begin
         bus.ad_busy   = (m < busy);
         bus.ad_valid  = (m == valid_at);
         bus.cmd_start = (m == 5) && (done_at > 6);
         if (bus.conv_start) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check($sformatf("%s conv_cycle", name), 32'(m), e);
            if (conv_idx < lat_q.size() && lat_q[conv_idx] != 0) valid_at = m + lat_q[conv_idx];
            conv_idx++;
         end
         if (bus.done) begin
            done_seen++;
            check($sformatf("%s done_cycle", name), 32'(m), 32'(done_at));
         end
         if (bus.timeout_err && !terr_seen) begin
            terr_seen = 1'b1;
            check($sformatf("%s timeout_cycle", name), 32'(m), 32'(terr_at));
            check($sformatf("%s cnt_at_timeout", name), 32'(bus.sample_cnt), 32'(terr_cnt));
         end
         step();
         m++;
      end
      bus.ad_valid  = 1'b0;
      bus.ad_busy   = 1'b0;
      bus.cmd_start = 1'b0;
      check($sformatf("%s missing_convs", name), 32'(exp_q.size()), 32'd0);
      check($sformatf("%s done_count", name), 32'(done_seen), 32'd1);
      check($sformatf("%s sample_cnt", name), 32'(bus.sample_cnt), 32'(burst));
      check($sformatf("%s overrun_cnt", name), 32'(bus.overrun_cnt), 32'(ovr));
      check($sformatf("%s running_end", name), 32'(bus.running), 32'd0);
      check($sformatf("%s timeout_err", name), 32'(bus.timeout_err), 32'(terr_at >= 0));
   endtask

   initial begin
      int div, burst, busy, p;

      rst           = 1'b1;
      bus.cfg_div   = '0;
      bus.cfg_burst = '0;
      bus.cmd_start = 1'b0;
      bus.cmd_stop  = 1'b0;
      bus.ad_busy   = 1'b0;
      bus.ad_valid  = 1'b0;
`ifdef AD_SCHED_EXT_TRIG_EN
      bus.ext_trig  = 1'b0;
`endif
      repeat (3) step();
      check("rst conv_start", 32'(bus.conv_start), 32'd0);
      check("rst running", 32'(bus.running), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst sample_cnt", 32'(bus.sample_cnt), 32'd0);
      check("rst overrun_cnt", 32'(bus.overrun_cnt), 32'd0);
      check("rst timeout_err", 32'(bus.timeout_err), 32'd0);
      check("rst state", 32'(state_dbg), 32'(IDLE));
      rst = 1'b0;
      step();

      // Directed cases from the plan plus divider boundaries.
      lat_q = '{3, 3, 3, 3};    run_case("nominal", 9, 4, 0);
      lat_q = '{12, 12, 12};    run_case("slow", 4, 3, 0);
      lat_q = '{1, 1};          run_case("busy", 9, 2, 7);
      lat_q = '{0, 5};          run_case("timeout", 99, 1, 0);
      lat_q = '{1, 1, 1};       run_case("div0", 0, 3, 0);
      lat_q = '{2, 2};          run_case("div1", 1, 2, 0);

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         div   = $urandom_range(0, 12);
         burst = $urandom_range(1, 5);
         busy  = $urandom_range(0, 6);
         p     = ((div < 1) ? 1 : div) + 1;
         lat_q.delete();
         for (int j = 0; j < burst; j++) lat_q.push_back($urandom_range(1, 3 * p));
         run_case($sformatf("rand%0d", r), div, burst, busy);
      end

      // Stop during WAIT_DONE goes through DRAIN; the late sample is counted, no done.
      do_start(9, 0);
      step();
      check("stop conv_start", 32'(bus.conv_start), 32'd1);
      step();
      step();
      bus.cmd_stop = 1'b1;
      step();
      bus.cmd_stop = 1'b0;
      check("stop state_drain", 32'(state_dbg), 32'(DRAIN));
      check("stop running_drain", 32'(bus.running), 32'd1);
      step();
      bus.ad_valid = 1'b1;
      step();
      bus.ad_valid = 1'b0;
      check("stop running", 32'(bus.running), 32'd0);
      check("stop sample_cnt", 32'(bus.sample_cnt), 32'd1);
      check("stop done", 32'(bus.done), 32'd0);
      step();
      check("stop done_late", 32'(bus.done), 32'd0);

      // Start and stop together in IDLE: nothing starts and counters are preserved.
      bus.cfg_burst = 16'd7;
      bus.cmd_start = 1'b1;
      bus.cmd_stop  = 1'b1;
      step();
      bus.cmd_start = 1'b0;
      bus.cmd_stop  = 1'b0;
      check("startstop running", 32'(bus.running), 32'd0);
      check("startstop state", 32'(state_dbg), 32'(IDLE));
      check("startstop sample_cnt", 32'(bus.sample_cnt), 32'd1);
      step();
      check("startstop conv", 32'(bus.conv_start), 32'd0);

      // Reset in WAIT_DONE with an overrun recorded; a late ad_valid is ignored.
      do_start(9, 0);
      for (int k = 0; k < 12; k++) step();
      check("rstrun state", 32'(state_dbg), 32'(WAIT_DONE));
      check("rstrun overrun_pre", 32'(bus.overrun_cnt), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstrun running", 32'(bus.running), 32'd0);
      check("rstrun overrun", 32'(bus.overrun_cnt), 32'd0);
      check("rstrun conv", 32'(bus.conv_start), 32'd0);
      check("rstrun done", 32'(bus.done), 32'd0);
      check("rstrun timeout_err", 32'(bus.timeout_err), 32'd0);
      check("rstrun state_idle", 32'(state_dbg), 32'(IDLE));
      bus.ad_valid = 1'b1;
      step();
      bus.ad_valid = 1'b0;
      check("rstrun late_valid", 32'(bus.sample_cnt), 32'd0);
      check("rstrun late_running", 32'(bus.running), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
